// File: rtl/instr_encoder_if.sv
// Request/write-port bundle between the boot loader (master) and instr_encoder (slave).
interface instr_encoder_if #(parameter int ADDR_W = 8);
  logic              clear_i;
  logic              valid_i;
  logic              ready_o;
  logic [2:0]        kind_i;
  logic [4:0]        rd_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [2:0]        funct3_i;
  logic [6:0]        funct7_i;
  logic [31:0]       imm_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;
  logic [ADDR_W:0]   words_o;
  logic              full_o;
  logic              err_o;
  logic              overflow_o;

  modport master (
    output clear_i, valid_i, kind_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    input  ready_o, wr_en_o, wr_addr_o, wr_data_o, words_o, full_o, err_o, overflow_o
  );

  modport slave (
    input  clear_i, valid_i, kind_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    output ready_o, wr_en_o, wr_addr_o, wr_data_o, words_o, full_o, err_o, overflow_o
  );
endinterface

// File: rtl/instr_encoder.sv
// Field-level request -> RV32 word encoder writing sequentially into program memory.
// LI expands to ADDI, or LUI (+ADDI when the low 12 bits are nonzero).
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input logic         clk,
  input logic         reset,
  instr_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT2 = 2'd1, FULL = 2'd2} state_t;

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_U = 7'b0110111;

  state_t            state, state_d;
  logic [ADDR_W:0]   words, words_d;
  logic [ADDR_W-1:0] wr_addr, wr_addr_d;
  logic [31:0]       wr_data, wr_data_d;
  logic [31:0]       pend, pend_d;
  logic              wr_en, wr_en_d;
  logic              err, err_d;
  logic              ovf, ovf_d;
  logic              li_small, li_two, accept;
  logic [19:0]       li_hi;
  logic [31:0]       first_word, second_word;

  assign li_small = (bus.imm_i[31:11] == '0) || (bus.imm_i[31:11] == '1);
  // (imm + 0x800) >> 12: the +0x800 carries into bit 12 exactly when imm[11] is set
  assign li_hi    = bus.imm_i[31:12] + 20'(bus.imm_i[11]);
  assign li_two   = (bus.kind_i == 3'd3) && !li_small && (bus.imm_i[11:0] != 12'd0);
  assign second_word = {bus.imm_i[11:0], bus.rd_i, 3'b000, bus.rd_i, OP_I};

  always_comb begin
    first_word = '0;
    case (bus.kind_i)
      3'd0: first_word = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i, OP_R};
      3'd1: first_word = {bus.imm_i[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, OP_I};
      3'd2: first_word = {bus.imm_i[31:12], bus.rd_i, OP_U};
      3'd3: first_word = li_small ? {bus.imm_i[11:0], 5'd0, 3'b000, bus.rd_i, OP_I}
                                  : {li_hi, bus.rd_i, OP_U};
      default: first_word = '0;
    endcase
  end

  assign accept = bus.valid_i && bus.ready_o;

  always_comb begin
    state_d   = state;
    words_d   = words;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    pend_d    = pend;
    wr_en_d   = 1'b0;
    err_d     = 1'b0;
    ovf_d     = ovf;
    if (bus.clear_i) begin
      state_d   = IDLE;
      words_d   = '0;
      wr_addr_d = '0;
      ovf_d     = 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (bus.kind_i[2]) begin
            err_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = words[ADDR_W-1:0];
            wr_data_d = first_word;
            words_d   = words + 1'b1;
            if (li_two) begin
              // only one slot left: keep the LUI, drop the ADDI
              if (words < LAST) begin
                pend_d  = second_word;
                state_d = EMIT2;
              end else begin
                ovf_d   = 1'b1;
                state_d = FULL;
              end
            end else if (words == LAST) begin
              state_d = FULL;
            end
          end
        end
        EMIT2: begin
          wr_en_d   = 1'b1;
          wr_addr_d = words[ADDR_W-1:0];
          wr_data_d = pend;
          words_d   = words + 1'b1;
          state_d   = (words == LAST) ? FULL : IDLE;
        end
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      words   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      pend    <= '0;
      wr_en   <= 1'b0;
      err     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_d;
      words   <= words_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      pend    <= pend_d;
      wr_en   <= wr_en_d;
      err     <= err_d;
      ovf     <= ovf_d;
    end
  end

  assign bus.ready_o    = (state == IDLE);
  assign bus.full_o     = (state == FULL);
  assign bus.wr_en_o    = wr_en;
  assign bus.wr_addr_o  = wr_addr;
  assign bus.wr_data_o  = wr_data;
  assign bus.words_o    = words;
  assign bus.err_o      = err;
  assign bus.overflow_o = ovf;
endmodule
